// File: rtl/orv64_clk_gate_ctrl.sv
// Per-channel idle-driven clock gating controller (RUN / GATED / WAKE).
// Define ORV64_CLK_GATE_EN for latch-based glitch-free gating; otherwise clkg passes clk through.
module orv64_clk_gate_ctrl #(
    parameter int N_CH     = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   busy,
    input  logic [N_CH-1:0]   wake_req,
    input  logic [N_CH-1:0]   force_on,
    input  logic [IDLE_W-1:0] idle_thresh,
    input  logic              tst_en,
    output logic [N_CH-1:0]   clkg,
    output logic [N_CH-1:0]   ch_en,
    output logic [N_CH-1:0]   wake_ack,
    output logic [N_CH-1:0]   gated
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_e;

    localparam logic [3:0] WAKE_LAST = 4'(WAKE_LAT - 1);

    state_e            state_r    [N_CH];
    state_e            state_s    [N_CH];
    logic [IDLE_W-1:0] idle_cnt_r [N_CH];
    logic [IDLE_W-1:0] idle_cnt_s [N_CH];
    logic [3:0]        wake_cnt_r [N_CH];
    logic [3:0]        wake_cnt_s [N_CH];
    logic [N_CH-1:0]   ch_en_r, gated_r, wake_ack_r;
    logic [N_CH-1:0]   ch_en_s, gated_s, wake_ack_s;
    logic [N_CH-1:0]   activity_s;
    logic              thresh_on_s;

    assign activity_s  = busy | force_on | wake_req;
    assign thresh_on_s = (idle_thresh != {IDLE_W{1'b0}});

    // Next-state, counter and registered-output decode for every channel
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_s[i]    = state_r[i];
            idle_cnt_s[i] = idle_cnt_r[i];
            wake_cnt_s[i] = wake_cnt_r[i];
            wake_ack_s[i] = 1'b0;
            case (state_r[i])
                ST_RUN: begin
                    wake_ack_s[i] = wake_req[i];
                    if (activity_s[i]) begin
                        idle_cnt_s[i] = {IDLE_W{1'b0}};
                        state_s[i]    = ST_RUN;
                    end else begin
                        if (&idle_cnt_r[i]) begin
                            idle_cnt_s[i] = idle_cnt_r[i];
                        end else begin
                            idle_cnt_s[i] = idle_cnt_r[i] + {{(IDLE_W-1){1'b0}}, 1'b1};
                        end
                        // compare one bit wider so an all-ones counter still reaches the threshold
                        if (thresh_on_s &&
                            (({1'b0, idle_cnt_r[i]} + {{IDLE_W{1'b0}}, 1'b1}) >= {1'b0, idle_thresh})) begin
                            state_s[i] = ST_GATED;
                        end else begin
                            state_s[i] = ST_RUN;
                        end
                    end
                end
                ST_GATED: begin
                    if (activity_s[i]) begin
                        state_s[i]    = ST_WAKE;
                        wake_cnt_s[i] = 4'd0;
                    end else begin
                        state_s[i] = ST_GATED;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt_r[i] == WAKE_LAST) begin
                        state_s[i]    = ST_RUN;
                        idle_cnt_s[i] = {IDLE_W{1'b0}};
                        wake_cnt_s[i] = 4'd0;
                        wake_ack_s[i] = 1'b1;
                    end else begin
                        wake_cnt_s[i] = wake_cnt_r[i] + 4'd1;
                    end
                end
                default: begin
                    state_s[i]    = ST_RUN;
                    idle_cnt_s[i] = {IDLE_W{1'b0}};
                    wake_cnt_s[i] = 4'd0;
                end
            endcase
            ch_en_s[i] = (state_s[i] != ST_GATED);
            gated_s[i] = (state_s[i] == ST_GATED);
        end
    end

    // State, counters and status outputs; reset wins over any pending wake completion
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_r[i]    <= ST_RUN;
                idle_cnt_r[i] <= {IDLE_W{1'b0}};
                wake_cnt_r[i] <= 4'd0;
            end
            ch_en_r    <= {N_CH{1'b1}};
            gated_r    <= {N_CH{1'b0}};
            wake_ack_r <= {N_CH{1'b0}};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_r[i]    <= state_s[i];
                idle_cnt_r[i] <= idle_cnt_s[i];
                wake_cnt_r[i] <= wake_cnt_s[i];
            end
            ch_en_r    <= ch_en_s;
            gated_r    <= gated_s;
            wake_ack_r <= wake_ack_s;
        end
    end

    assign ch_en    = ch_en_r;
    assign gated    = gated_r;
    assign wake_ack = wake_ack_r;

`ifdef ORV64_CLK_GATE_EN
    logic [N_CH-1:0] en_lat_r;

    // Enable latch open while clk is low so the AND gate never sees a mid-high change
    always_latch begin
        if (!clk) begin
            en_lat_r <= ch_en_r | {N_CH{tst_en}};
        end
    end

    assign clkg = {N_CH{clk}} & en_lat_r;
`else
    logic unused_tst_en_s;

    assign unused_tst_en_s = tst_en;
    assign clkg            = {N_CH{clk}};
`endif

endmodule

// File: doc/orv64_clk_gate_ctrl.md
ORV64_CLK_GATE_CTRL -- requirements
Module: orv64_clk_gate_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independently gated clock channels, range 1..16.
REQ-002 SHALL have parameter IDLE_W, default 8: width of the idle counter and threshold.
REQ-003 SHALL have parameter WAKE_LAT, default 2: cycles spent in WAKE before RUN, range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state is sampled on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port busy, input, N_CH bits: per-channel activity from the clocked logic.
REQ-007 SHALL have port wake_req, input, N_CH bits: per-channel request to resume the clock.
REQ-008 SHALL have port force_on, input, N_CH bits: software override that holds the channel clock running.
REQ-009 SHALL have port idle_thresh, input, IDLE_W bits: shared idle-cycle threshold; 0 disables auto-gating.
REQ-010 SHALL have port tst_en, input, 1 bit: scan/test enable; forces every clkg running.
REQ-011 SHALL have port clkg, output, N_CH bits: gated clock per channel.
REQ-012 SHALL have port ch_en, output, N_CH bits: registered gate enable per channel.
REQ-013 SHALL have port wake_ack, output, N_CH bits: one-cycle pulse when a wake completes.
REQ-014 SHALL have port gated, output, N_CH bits: status; 1 while the channel is in GATED.

Function
REQ-015 SHALL run an independent FSM per channel with states RUN, GATED and WAKE, plus an IDLE_W-bit idle counter.
REQ-016 In RUN, the channel SHALL clear the counter when busy=1, force_on=1 or wake_req=1, and SHALL otherwise increment it, saturating at all-ones.
REQ-017 RUN SHALL go to GATED when idle_thresh!=0, busy=0, force_on=0, wake_req=0 and counter+1>=idle_thresh; a lowered threshold therefore gates on the next qualifying cycle.
REQ-018 In RUN with busy=1 on the cycle the threshold is reached, the channel SHALL stay in RUN and clear the counter (busy wins).
REQ-019 GATED SHALL go to WAKE when busy, wake_req or force_on is 1; otherwise it SHALL hold.
REQ-020 WAKE SHALL last exactly WAKE_LAT cycles, tracked by a 4-bit counter, and SHALL then go to RUN with the idle counter cleared; inputs during WAKE SHALL NOT abort it.
REQ-021 ch_en SHALL be 1 in RUN and WAKE and 0 in GATED, registered, and SHALL change in the cycle after the state transition.
REQ-022 wake_ack SHALL pulse for 1 cycle on the WAKE->RUN transition, and SHALL also pulse the cycle after a wake_req sampled in RUN.
REQ-023 gated SHALL equal (state==GATED), registered.
REQ-024 clkg SHALL run whenever tst_en=1, combinationally, regardless of state; tst_en SHALL NOT alter FSM state or counters.
REQ-025 idle_thresh SHALL be sampled every cycle; changing it to 0 SHALL stop new gating but SHALL NOT wake a channel already in GATED.

Reset
REQ-026 While rst=1, every channel SHALL enter RUN with idle and wake counters 0.
REQ-027 Reset values SHALL be ch_en=all ones, gated=0 and wake_ack=0; clkg SHALL run during and after reset.
REQ-028 A reset asserted in GATED or WAKE SHALL force RUN on the next edge without a wake_ack pulse.

Configuration
REQ-029 With macro ORV64_CLK_GATE_EN defined, each clkg SHALL equal clk AND (ch_en OR tst_en) captured in a latch transparent while clk is low, giving glitch-free gating.
REQ-030 Without ORV64_CLK_GATE_EN, each clkg SHALL equal clk (pass-through for FPGA), while the FSM, ch_en, gated and wake_ack behave identically.

Verification
REQ-031 With rst released, idle_thresh=4 and busy=0, channel 0 SHALL reach gated=1 and ch_en=0 four cycles after reset; with the macro defined, clkg[0] SHALL stop.
REQ-032 With channel 0 gated and wake_req[0] pulsed 1 cycle, WAKE_LAT=2: ch_en SHALL rise 1 cycle later, wake_ack SHALL pulse 3 cycles after the request, then gated=0.
REQ-033 With idle_thresh=3 and busy asserted on the 3rd idle cycle, the channel SHALL stay in RUN, the counter SHALL clear, and no gating SHALL occur until 3 further idle cycles.
REQ-034 With channels 1..3 gated and tst_en=1, all clkg SHALL toggle while gated stays 4'b1110; after tst_en=0, clkg[1..3] SHALL stop again.
REQ-035 With force_on[2]=1 and idle_thresh=1 for 100 cycles, channel 2 SHALL never gate; after force_on is released, it SHALL gate on the 1st idle cycle.
REQ-036 With rst asserted while a channel is in WAKE, the next cycle SHALL show RUN, ch_en=1 and wake_ack=0.
